// File: rtl/sccb_target_regfile.sv
// SCCB/I2C target with a 256x8 register file. It takes 3-phase writes with burst
// auto-increment and 2-phase reads, and exposes a fabric-side read port.
module sccb_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       busy_q;
  logic [7:0] host_data_q;
  logic [7:0] regs_q [256];

  logic [7:0] byte_in;
  logic [7:0] ptr_inc;

  // Synchronizers reset to the idle-bus level so reset never fakes a START.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_in   = {shift_q[6:0], sda_s};
  assign ptr_inc   = ptr_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      host_data_q <= '0;
      for (int i = 0; i < 256; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= (state_d != ST_IDLE);
      host_data_q <= regs_q[host_addr];
      if (wr_en_d) regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  // phase_q marks the second half of an ACK slot, or a read ACK already taken.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    phase_d   = phase_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
        if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            phase_d = 1'b0;
            case (state_q)
              ST_DEV_ADDR: begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  rw_d    = byte_in[0];
                  state_d = ST_DEV_ACK;
                end else begin
                  state_d = ST_IDLE;
                end
              end
              ST_REG_ADDR: begin
                ptr_d   = byte_in;
                state_d = ST_REG_ACK;
              end
              default: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_inc;
                state_d   = ST_WR_ACK;
              end
            endcase
          end
        end
      end

      ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
        if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            cnt_d    = '0;
            if (state_q == ST_DEV_ACK && rw_q) begin
              tx_d     = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
              state_d  = ST_RD_DATA;
            end else if (state_q == ST_DEV_ACK) begin
              state_d = ST_REG_ADDR;
            end else begin
              state_d = ST_WR_DATA;
            end
          end
        end
      end

      ST_RD_DATA: begin
        if (scl_fall) begin
          cnt_d = cnt_q + 3'd1;
          tx_d  = {tx_q[6:0], 1'b0};
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = ST_RD_ACK;
          end else begin
            sda_oe_d = ~tx_q[6];
          end
        end
      end

      ST_RD_ACK: begin
        if (!phase_q) begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d   = ptr_inc;
              tx_d    = regs_q[ptr_inc];
              phase_d = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end else if (scl_fall) begin
          sda_oe_d = ~tx_q[7];
          phase_d  = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RD_DATA;
        end
      end

      default: begin
      end
    endcase

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      phase_d  = 1'b0;
      wr_en_d  = 1'b0;
    end
    if (start_det) begin
      state_d  = ST_DEV_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      phase_d  = 1'b0;
      wr_en_d  = 1'b0;
    end
  end

  assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign host_data   = host_data_q;
  assign busy        = busy_q;

endmodule
